ibex_fetch_buf: RTL and testbench

Parametrised successor to the core's fetch FIFO. It holds word-aligned instruction fetch responses in a circular buffer of configurable depth and realigns them into 16/32-bit instructions with PC tracking. It reports occupancy and free credits to the prefetch controller instead of per-entry busy bits, and flags overflow. It sits between the instruction-bus response path and the ID stage.

---
 rtl/ibex_fetch_buf.sv | 196 +++++++++++++++++++
 tb/tb_ibex_fetch_buf.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_buf.sv
// ibex_fetch_buf
// Circular buffer of word-aligned instruction fetch responses feeding the ID
// stage. Stored words are realigned into 16/32-bit instructions with PC
// tracking. The prefetcher sees occupancy/free credits and a sticky overflow.
//
// Optional feature macro: IBEX_FETCH_BUF_RVC_EN
//   defined   -> compressed (16-bit) instructions and halfword-aligned PCs
//   undefined -> every instruction is a 32-bit aligned word
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clear_i             flush stored words and load PC from clear_addr_i
//   clear_addr_i        new PC (bit 0 ignored; bits 1:0 ignored without RVC)
//   in_valid_i/in_rdata_i/in_err_i   fetch response word
//   out_valid_o/out_ready_i          instruction handshake
//   out_addr_o/out_addr_next_o       PC of current/following instruction
//   out_rdata_o/out_err_o/out_err_plus2_o  instruction bits and error flags
//   count_o/free_o      stored entries and remaining credits
//   overflow_o          sticky: a word was dropped while full
module ibex_fetch_buf #(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned DEPTH    = NUM_REQS + 1,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [31:0]      clear_addr_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_rdata_i,
  input  logic             in_err_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_addr_o,
  output logic [31:0]      out_addr_next_o,
  output logic [31:0]      out_rdata_o,
  output logic             out_err_o,
  output logic             out_err_plus2_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] free_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      mem_data [DEPTH];
  logic [DEPTH-1:0] mem_err;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:1]      pc;
  logic             overflow;

  logic             has1;
  logic             head_valid;
  logic [31:0]      head_data;
  logic             head_err;

  logic             instr_valid;
  logic [31:0]      instr;
  logic             compressed;
  logic             instr_err;
  logic             instr_err_plus2;
  logic             consume_word;

  logic             handshake;
  logic             consume;
  logic             pop;
  logic             push_req;
  logic             full;
  logic             push;
  logic             drop;
  logic [31:1]      pc_next_seq;
  logic [31:1]      pc_clear;
  logic             unused_bits;

  // Pointers wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Head word: oldest stored entry, or the incoming word when empty.
  assign has1       = (count != '0);
  assign head_valid = has1 | in_valid_i;
  assign head_data  = has1 ? mem_data[rd_ptr] : in_rdata_i;
  assign head_err   = has1 ? mem_err[rd_ptr]  : in_err_i;

`ifdef IBEX_FETCH_BUF_RVC_EN
  logic             has2;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic             sec_valid;
  logic [31:0]      sec_data;
  logic             sec_err;

  // Second word supplies the upper half of an unaligned 32-bit instruction.
  assign has2      = (count > CNT_W'(1));
  assign rd_ptr_p1 = ptr_inc(rd_ptr);
  assign sec_valid = has2 | ((count == CNT_W'(1)) & in_valid_i);
  assign sec_data  = has2 ? mem_data[rd_ptr_p1] : in_rdata_i;
  assign sec_err   = (has2 ? mem_err[rd_ptr_p1] : in_err_i) & sec_valid;

  always_comb begin
    instr           = head_data;
    compressed      = 1'b0;
    instr_valid     = head_valid;
    instr_err       = head_err;
    instr_err_plus2 = 1'b0;
    consume_word    = 1'b1;
    if (!pc[1]) begin
      compressed   = (head_data[1:0] != 2'b11) & ~head_err;
      consume_word = ~compressed;
    end else begin
      instr           = {sec_data[15:0], head_data[31:16]};
      compressed      = (head_data[17:16] != 2'b11) & ~head_err;
      instr_valid     = head_valid & (compressed | sec_valid);
      instr_err       = head_err | (sec_err & ~compressed);
      instr_err_plus2 = sec_err & ~head_err & ~compressed;
    end
  end

  assign pc_clear    = clear_addr_i[31:1];
  assign out_addr_o  = {pc, 1'b0};
  assign unused_bits = clear_addr_i[0];
`else
  always_comb begin
    instr           = head_data;
    compressed      = 1'b0;
    instr_valid     = head_valid;
    instr_err       = head_err;
    instr_err_plus2 = 1'b0;
    consume_word    = 1'b1;
  end

  assign pc_clear    = {clear_addr_i[31:2], 1'b0};
  assign out_addr_o  = {pc[31:2], 2'b00};
  assign unused_bits = ^{clear_addr_i[1:0], pc[1]};
`endif

  assign pc_next_seq = pc + (compressed ? 31'd1 : 31'd2);

  assign out_valid_o     = instr_valid & ~rst_i;
  assign out_rdata_o     = instr;
  assign out_err_o       = instr_err;
  assign out_err_plus2_o = instr_err_plus2;
  assign out_addr_next_o = {pc_next_seq, 1'b0};

  assign handshake = out_valid_o & out_ready_i;
  assign consume   = handshake & consume_word;
  assign pop       = consume & has1;
  // A bypassed word consumed in the same cycle never enters storage.
  assign push_req  = in_valid_i & ~(~has1 & consume);
  assign full      = (count == CNT_W'(DEPTH));
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  assign count_o    = count;
  assign free_o     = CNT_W'(DEPTH) - count;
  assign overflow_o = overflow;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pc       <= '0;
      overflow <= 1'b0;
    end else if (clear_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pc       <= pc_clear;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end
      if (handshake) begin
        pc <= pc_next_seq;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push & ~rst_i & ~clear_i) begin
      mem_data[wr_ptr] <= in_rdata_i;
      mem_err[wr_ptr]  <= in_err_i;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_buf.sv
module tb_ibex_fetch_buf;

  logic        clk = 1'b0;
  logic        rst, clr, iv, ierr, rdy;
  logic [31:0] clr_addr, idata;

  logic        o3_valid, o3_err, o3_plus2, o3_ovf;
  logic [31:0] o3_addr, o3_addr_next, o3_rdata;
  logic [1:0]  o3_count, o3_free;
  logic        o5_valid, o5_err, o5_plus2, o5_ovf;
  logic [31:0] o5_addr, o5_addr_next, o5_rdata;
  logic [2:0]  o5_count, o5_free;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  ibex_fetch_buf #(.NUM_REQS(2)) u3 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .clear_addr_i(clr_addr),
    .in_valid_i(iv), .in_rdata_i(idata), .in_err_i(ierr),
    .out_valid_o(o3_valid), .out_ready_i(rdy), .out_addr_o(o3_addr),
    .out_addr_next_o(o3_addr_next), .out_rdata_o(o3_rdata), .out_err_o(o3_err),
    .out_err_plus2_o(o3_plus2), .count_o(o3_count), .free_o(o3_free),
    .overflow_o(o3_ovf)
  );

  ibex_fetch_buf #(.NUM_REQS(4)) u5 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .clear_addr_i(clr_addr),
    .in_valid_i(iv), .in_rdata_i(idata), .in_err_i(ierr),
    .out_valid_o(o5_valid), .out_ready_i(rdy), .out_addr_o(o5_addr),
    .out_addr_next_o(o5_addr_next), .out_rdata_o(o5_rdata), .out_err_o(o5_err),
    .out_err_plus2_o(o5_plus2), .count_o(o5_count), .free_o(o5_free),
    .overflow_o(o5_ovf)
  );

`ifdef IBEX_FETCH_BUF_RVC_EN
  localparam logic [31:0] PC_MASK = 32'hffff_fffe;
`else
  localparam logic [31:0] PC_MASK = 32'hffff_fffc;
`endif

  typedef struct {
    bit          valid;
    bit          comp;
    int unsigned consume;
    logic [31:0] rdata;
    logic        err;
    logic        plus2;
    logic [31:0] addr_next;
  } mout_t;

  // Reference state: each buffer is a queue of {err, word} in arrival order.
  logic [32:0] q3[$];
  logic [32:0] q5[$];
  logic [31:0] pc3, pc5;
  bit          ov3, ov5;
  mout_t       p3, p5;

  // Halfword-stream view of the available words (stored + incoming).
  function automatic mout_t predict(input int unsigned nq, input logic [32:0] q0,
                                    input logic [32:0] q1, input logic v,
                                    input logic [32:0] iw, input logic [31:0] pc);
    mout_t       r;
    logic [32:0] w [2];
    logic [15:0] hw [4];
    logic        he [4];
    int unsigned nw, off, len;
    w[0] = q0;
    w[1] = q1;
    nw = (nq > 2) ? 2 : nq;
    if (nw < 2 && v) begin
      w[nw] = iw;
      nw++;
    end
    for (int i = 0; i < 4; i++) begin
      hw[i] = '0;
      he[i] = 1'b0;
    end
    for (int unsigned i = 0; i < nw; i++) begin
      hw[2*i]   = w[i][15:0];
      hw[2*i+1] = w[i][31:16];
      he[2*i]   = w[i][32];
      he[2*i+1] = w[i][32];
    end
`ifdef IBEX_FETCH_BUF_RVC_EN
    off    = pc[1] ? 1 : 0;
    r.comp = (2*nw > off) && (hw[off][1:0] != 2'b11) && !he[off];
`else
    off    = 0;
    r.comp = 1'b0;
`endif
    len         = r.comp ? 1 : 2;
    r.valid     = (2*nw >= off + len);
    r.rdata     = {hw[off+1], hw[off]};
    r.err       = he[off] | ((len == 2) & he[off+1]);
    r.plus2     = (len == 2) & he[off+1] & ~he[off];
    r.consume   = (off + len) / 2;
    r.addr_next = pc + 32'(2 * len);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [31:0] ca, input logic v,
                       input logic [31:0] d, input logic e, input logic r);
    clr = c; clr_addr = ca; iv = v; idata = d; ierr = e; rdy = r;
  endtask

  task automatic observe();
    logic [31:0] m3, m5;
    @(negedge clk);
    p3 = predict(q3.size(), (q3.size() > 0) ? q3[0] : '0, (q3.size() > 1) ? q3[1] : '0,
                 iv, {ierr, idata}, pc3);
    p5 = predict(q5.size(), (q5.size() > 0) ? q5[0] : '0, (q5.size() > 1) ? q5[1] : '0,
                 iv, {ierr, idata}, pc5);
    if (rst) begin
      chk("valid3_rst", 32'(o3_valid), 32'd0);
      chk("valid5_rst", 32'(o5_valid), 32'd0);
    end else begin
      chk("valid3", 32'(o3_valid), 32'(p3.valid));
      chk("addr3", o3_addr, pc3);
      chk("count3", 32'(o3_count), 32'(q3.size()));
      chk("free3", 32'(o3_free), 32'(3 - q3.size()));
      chk("ovf3", 32'(o3_ovf), 32'(ov3));
      chk("valid5", 32'(o5_valid), 32'(p5.valid));
      chk("addr5", o5_addr, pc5);
      chk("count5", 32'(o5_count), 32'(q5.size()));
      chk("free5", 32'(o5_free), 32'(5 - q5.size()));
      chk("ovf5", 32'(o5_ovf), 32'(ov5));
      chk("cnt5_bound", 32'(o5_count <= 3'd5), 32'd1);
      if (p3.valid) begin
        m3 = p3.comp ? 32'h0000_ffff : 32'hffff_ffff;
        chk("rdata3", o3_rdata & m3, p3.rdata & m3);
        chk("anext3", o3_addr_next, p3.addr_next);
        chk("err3", 32'(o3_err), 32'(p3.err));
        chk("plus2_3", 32'(o3_plus2), 32'(p3.plus2));
      end
      if (p5.valid) begin
        m5 = p5.comp ? 32'h0000_ffff : 32'hffff_ffff;
        chk("rdata5", o5_rdata & m5, p5.rdata & m5);
        chk("anext5", o5_addr_next, p5.addr_next);
        chk("err5", 32'(o5_err), 32'(p5.err));
        chk("plus2_5", 32'(o5_plus2), 32'(p5.plus2));
      end
    end
  endtask

  task automatic tick();
    bit hs3, hs5;
    hs3 = !rst && p3.valid && rdy;
    hs5 = !rst && p5.valid && rdy;
    @(posedge clk);
    if (rst) begin
      q3.delete(); pc3 = '0; ov3 = 1'b0;
      q5.delete(); pc5 = '0; ov5 = 1'b0;
    end else if (clr) begin
      q3.delete(); pc3 = clr_addr & PC_MASK; ov3 = 1'b0;
      q5.delete(); pc5 = clr_addr & PC_MASK; ov5 = 1'b0;
    end else begin
      if (iv) q3.push_back({ierr, idata});
      if (hs3 && p3.consume > 0) void'(q3.pop_front());
      if (q3.size() > 3) begin void'(q3.pop_back()); ov3 = 1'b1; end
      if (hs3) pc3 = p3.addr_next;
      if (iv) q5.push_back({ierr, idata});
      if (hs5 && p5.consume > 0) void'(q5.pop_front());
      if (q5.size() > 5) begin void'(q5.pop_back()); ov5 = 1'b1; end
      if (hs5) pc5 = p5.addr_next;
    end
    #1;
  endtask

  task automatic cyc();
    observe();
    tick();
  endtask

  initial begin
    pc3 = '0; pc5 = '0; ov3 = 1'b0; ov5 = 1'b0;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    cyc(); cyc();
    rst = 1'b0;

    // Bypass of a single aligned word into an empty buffer.
    drive(1'b0, '0, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
    observe();
    chk("byp_valid", 32'(o3_valid), 32'd1);
    chk("byp_addr", o3_addr, 32'h0);
    chk("byp_count", 32'(o3_count), 32'd0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    observe();
    chk("byp_addr_next", o3_addr, 32'h4);
    chk("byp_count_after", 32'(o3_count), 32'd0);
    tick();

    // Clear to 0x102, then a compressed halfword followed by a full word.
    drive(1'b1, 32'h0000_0102, 1'b0, '0, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b1, 32'h0001_4501, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b1, 32'h0000_0513, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    observe();
`ifdef IBEX_FETCH_BUF_RVC_EN
    chk("rvc_addr0", o3_addr, 32'h102);
    chk("rvc_lo0", 32'(o3_rdata[15:0]), 32'h0001);
    chk("rvc_next0", o3_addr_next, 32'h104);
`else
    chk("rvc_addr0", o3_addr, 32'h100);
    chk("rvc_w0", o3_rdata, 32'h0001_4501);
`endif
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    observe();
    chk("rvc_addr1", o3_addr, 32'h104);
    chk("rvc_w1", o3_rdata, 32'h0000_0513);
    chk("rvc_next1", o3_addr_next, 32'h108);
    tick();

    // Fill past capacity with the consumer stalled.
    drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b0); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, $urandom, 1'b0, 1'b0); cyc();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    observe();
    chk("full_count3", 32'(o3_count), 32'd3);
    chk("full_free3", 32'(o3_free), 32'd0);
    chk("full_ovf3", 32'(o3_ovf), 32'd1);
    chk("full_count5", 32'(o5_count), 32'd4);
    chk("full_ovf5", 32'(o5_ovf), 32'd0);
    tick();
    drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    observe();
    chk("clr_count3", 32'(o3_count), 32'd0);
    chk("clr_ovf3", 32'(o3_ovf), 32'd0);
    tick();

    // Split 32-bit instruction errors: second word only, then both words.
    drive(1'b1, 32'h2, 1'b0, '0, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b1, 32'h0003_0000, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b1, 32'h1234_5678, 1'b1, 1'b0); cyc();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    observe();
    chk("split_valid", 32'(o3_valid), 32'd1);
`ifdef IBEX_FETCH_BUF_RVC_EN
    chk("split_rdata", o3_rdata, 32'h5678_0003);
    chk("split_err", 32'(o3_err), 32'd1);
    chk("split_plus2", 32'(o3_plus2), 32'd1);
`else
    chk("split_rdata", o3_rdata, 32'h0003_0000);
    chk("split_err", 32'(o3_err), 32'd0);
    chk("split_plus2", 32'(o3_plus2), 32'd0);
`endif
    tick();
    drive(1'b1, 32'h2, 1'b0, '0, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b1, 32'h0003_0000, 1'b1, 1'b0); cyc();
    drive(1'b0, '0, 1'b1, 32'h1234_5678, 1'b1, 1'b0); cyc();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    observe();
    chk("both_err", 32'(o3_err), 32'd1);
    chk("both_plus2", 32'(o3_plus2), 32'd0);
    tick();

    // Clear wins over a simultaneous push and handshake.
    drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b1, 32'h0000_0013, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h0000_0200, 1'b1, 32'h0040_0093, 1'b0, 1'b1);
    observe();
    chk("clrhs_valid", 32'(o3_valid), 32'd1);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    observe();
    chk("clrhs_count", 32'(o3_count), 32'd0);
    chk("clrhs_addr", o3_addr, 32'h200);
    tick();

    // Random stream with random back-pressure and occasional clears.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(63) == 0), $urandom & 32'h0000_fffe,
            ($urandom_range(3) != 0), $urandom, ($urandom_range(15) == 0),
            1'($urandom_range(1)));
      cyc();
    end

    // Reset in the middle of traffic discards everything.
    drive(1'b0, '0, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    observe();
    chk("mid_rst_count5", 32'(o5_count), 32'd0);
    chk("mid_rst_addr5", o5_addr, 32'h0);
    chk("mid_rst_free5", 32'(o5_free), 32'd5);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
